hsv_out_buffer: RTL
===================

Name: hsv_out_buffer

Overview:
- Downstream stage of the RGB->HSV datapath: captures each valid {H, S, V} triple (three 32-bit IEEE-754 single words) into a FIFO.
- Serializes each triple into three 32-bit memory writes over a valid/ack interface.
- Generates sequential write addresses per frame and flags frame completion.
- Absorbs the datapath's lack of backpressure: the datapath cannot stall, so pixels arriving on a full FIFO are dropped and flagged.

Parameters:
- DEPTH, 8, FIFO depth in pixels (power of 2, >=2)
- ADDR_W, 16, memory word-address width
- BASE_ADDR, 0, first word address of each frame
- NUM_PIXELS, 64, pixels per frame (>=1; frame = 3*NUM_PIXELS words)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- h_in  input  32  hue word from datapath
- s_in  input  32  saturation word
- v_in  input  32  value word
- in_valid  input  1  triple valid this cycle (datapath Valid_Out gated by Enable)
- mem_wr_en  output  1  write request; held until mem_ack
- mem_addr  output  ADDR_W  word address of current write
- mem_wdata  output  32  write data
- mem_ack  input  1  memory accepted the current write this cycle
- fifo_full  output  1  FIFO holds DEPTH entries
- fifo_empty  output  1  FIFO holds 0 entries
- overflow  output  1  sticky: at least one pixel was dropped
- clr_overflow  input  1  synchronous clear of overflow
- frame_done  output  1  one-cycle pulse when the last word of a frame is acked

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and count = 0; fifo_empty=1, fifo_full=0.
  - FSM=IDLE; mem_wr_en=0; mem_wdata=0; mem_addr=BASE_ADDR.
  - Pixel counter=0; overflow=0; frame_done=0.
  - Reset mid-write abandons the write and discards all FIFO contents.
- Push:
  - If in_valid && !fifo_full, write {h_in,s_in,v_in} at the write pointer; pointer wraps modulo DEPTH.
  - If in_valid && fifo_full, drop the pixel and set overflow on the next edge.
  - fifo_full is based on the registered count, so a push on a full FIFO is dropped even if a pop occurs in the same cycle.
- Overflow flag:
  - clr_overflow clears it.
  - If clr_overflow and a drop occur in the same cycle, the set wins.
- Count update: a simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, WR_H, WR_S, WR_V.
  - IDLE: if !fifo_empty, pop into a 96-bit hold register and go to WR_H; otherwise stay.
  - WR_H: mem_wr_en=1, mem_wdata=H. On mem_ack: mem_addr+1, go to WR_S.
  - WR_S: same with S; on mem_ack go to WR_V.
  - WR_V: same with V. On mem_ack:
    - If pixel counter==NUM_PIXELS-1: frame_done=1 for one cycle, pixel counter=0, mem_addr=BASE_ADDR.
    - Otherwise: pixel counter+1, mem_addr+1.
    - In both cases go to IDLE.
- Write interface rules:
  - mem_addr and mem_wdata stay stable while mem_wr_en=1 and mem_ack=0.
  - mem_ack while mem_wr_en=0 is ignored.
- Latency:
  - Push at edge N makes the FIFO non-empty.
  - IDLE pops at edge N+1; mem_wr_en=1 for H from N+1 to N+2.
  - Minimum 4 cycles per pixel with mem_ack tied high.
- Address arithmetic: modulo 2^ADDR_W.
- FIFO data: passes through unmodified. No float interpretation and no NaN checks.

Optional Feature:
- Macro: HSV_OUT_DROP_CNT_EN.
- Defined:
  - Adds output port drop_count (16 bits): saturating count of dropped pixels, reset to 0.
  - clr_overflow also clears drop_count.
  - A drop in the same cycle as clr_overflow leaves drop_count=1.
- Undefined: no drop_count port and no counter logic; overflow behaviour is unchanged.

Decomposition:
- Shared package:
  - FSM state encoding (2-bit).
  - HSV_W=32 and the triple width 3*HSV_W.
  - Word-offset constants (H=0, S=1, V=2).
- One natural sub-module: hsv_sync_fifo (parameterized width/depth, registered count, full/empty). The FSM, address generator and counters stay in the top level.

Test Plan:
- Single pixel (green): H=0x42F00000, S=0x3F800000, V=0x3F800000, mem_ack=1 -> writes at addr 0, 1, 2 with those words in order; fifo_empty returns to 1; no frame_done.
- Ack stall: hold mem_ack=0 for 5 cycles during WR_S -> mem_wr_en=1 with addr=1 and wdata=0x3F800000 held stable; resumes on ack.
- Overflow: DEPTH=8, mem_ack=0, 10 consecutive in_valid -> first 8 stored (1 popped into the hold register, so 9 accepted), overflow=1. With HSV_OUT_DROP_CNT_EN, drop_count=1. After clr_overflow: overflow=0.
- Frame wrap: NUM_PIXELS=4, push 5 pixels, mem_ack=1 -> frame_done pulses once after the word at addr 11 is acked; 5th pixel written to addrs 0-2.
- Async reset mid-write: assert rst during WR_V -> outputs take reset values immediately; after release, the FIFO is empty and the next pixel writes at BASE_ADDR.
- Simultaneous push and pop with count=3: count stays 3; data order is preserved on the output.

Source files
------------

// File: rtl/hsv_out_buffer_pkg.sv
// Shared types and constants for the HSV output buffer: word widths, FSM
// state encoding, word offsets within a triple and a word-select helper.
package hsv_out_buffer_pkg;

    localparam int unsigned HSV_W      = 32;
    localparam int unsigned TRIPLE_W   = 3 * HSV_W;
    localparam int unsigned DROP_CNT_W = 16;

    // Word offsets of H, S and V inside one serialized pixel
    localparam logic [1:0] WORD_H = 2'd0;
    localparam logic [1:0] WORD_S = 2'd1;
    localparam logic [1:0] WORD_V = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR_H = 2'd1,
        ST_WR_S = 2'd2,
        ST_WR_V = 2'd3
    } wr_state_e;

    typedef struct packed {
        logic [HSV_W-1:0] h;
        logic [HSV_W-1:0] s;
        logic [HSV_W-1:0] v;
    } hsv_triple_t;

    // Pick one word of a triple by its write offset
    function automatic logic [HSV_W-1:0] hsv_word(input hsv_triple_t t, input logic [1:0] idx);
        case (idx)
            WORD_H:  return t.h;
            WORD_S:  return t.s;
            default: return t.v;
        endcase
    endfunction

endpackage

// File: rtl/hsv_out_buffer_if.sv
// Datapath-side pixel input plus memory-side write handshake of the HSV
// output buffer. slave = the buffer, master = the datapath/memory side.
interface hsv_out_buffer_if #(
    parameter int unsigned ADDR_W = 16
);
    import hsv_out_buffer_pkg::*;

    logic [HSV_W-1:0]  h_in;
    logic [HSV_W-1:0]  s_in;
    logic [HSV_W-1:0]  v_in;
    logic              in_valid;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [HSV_W-1:0]  mem_wdata;
    logic              mem_ack;

    modport master (
        output h_in, s_in, v_in, in_valid, mem_ack,
        input  mem_wr_en, mem_addr, mem_wdata
    );

    modport slave (
        input  h_in, s_in, v_in, in_valid, mem_ack,
        output mem_wr_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/hsv_sync_fifo.sv
// Single-clock FIFO with registered occupancy count and registered
// full/empty flags. Pushes on full and pops on empty are ignored.
module hsv_sync_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata_c = mem[rd_ptr];

    // Occupancy update; simultaneous push and pop cancel out
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Pointers, count and flags; reset discards all contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage array needs no reset: validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/hsv_out_buffer.sv
// HSV output buffer: queues {H,S,V} triples from a non-stalling datapath
// and writes each as three sequential memory words, wrapping the address
// at the end of every frame. Pixels arriving on a full FIFO are dropped.
// Optional feature macro: HSV_OUT_DROP_CNT_EN adds a saturating drop_count.
module hsv_out_buffer
    import hsv_out_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned NUM_PIXELS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    hsv_out_buffer_if.slave       bus,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  overflow,
    input  logic                  clr_overflow,
`ifdef HSV_OUT_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] drop_count,
`endif
    output logic                  frame_done
);

    localparam int unsigned PIX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    wr_state_e         state_q, state_d;
    hsv_triple_t       hold_q;
    hsv_triple_t       fifo_rdata;
    logic              wr_en_q, wr_en_d;
    logic [HSV_W-1:0]  wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              frame_done_d;
    logic              pop_c;
    logic              drop_c;

    assign bus.mem_wr_en = wr_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign drop_c        = bus.in_valid && fifo_full;

    hsv_sync_fifo #(
        .WIDTH (TRIPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.in_valid),
        .wdata   ({bus.h_in, bus.s_in, bus.v_in}),
        .pop     (pop_c),
        .rdata_c (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Serializer next-state: pop a triple, then write H, S, V with ack handshakes
    always_comb begin
        state_d      = state_q;
        wr_en_d      = wr_en_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        pix_d        = pix_q;
        frame_done_d = 1'b0;
        pop_c        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    state_d = ST_WR_H;
                    wr_en_d = 1'b1;
                    wdata_d = hsv_word(fifo_rdata, WORD_H);
                end
            end
            ST_WR_H: begin
                if (bus.mem_ack) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_WR_S;
                    wdata_d = hsv_word(hold_q, WORD_S);
                end
            end
            ST_WR_S: begin
                if (bus.mem_ack) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_WR_V;
                    wdata_d = hsv_word(hold_q, WORD_V);
                end
            end
            ST_WR_V: begin
                if (bus.mem_ack) begin
                    wr_en_d = 1'b0;
                    state_d = ST_IDLE;
                    if (pix_q == PIX_W'(NUM_PIXELS - 1)) begin
                        frame_done_d = 1'b1;
                        pix_d        = '0;
                        addr_d       = ADDR_W'(BASE_ADDR);
                    end else begin
                        pix_d  = pix_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serializer state and registered write-port outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_en_q    <= 1'b0;
            wdata_q    <= '0;
            addr_q     <= ADDR_W'(BASE_ADDR);
            pix_q      <= '0;
            frame_done <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            pix_q      <= pix_d;
            frame_done <= frame_done_d;
            if (pop_c) hold_q <= fifo_rdata;
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef HSV_OUT_DROP_CNT_EN
    // Saturating count of dropped pixels, cleared together with overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (clr_overflow) begin
            drop_count <= drop_c ? DROP_CNT_W'(1) : '0;
        end else if (drop_c && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule
